// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, alignment check, byte-lane store
// masking/replication and load extraction with sign/zero extension.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              store_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              req_illegal;

  function automatic logic illegal_req(input logic st, input logic [2:0] f3,
                                       input logic [1:0] a);
    logic bad_f3, bad_align;
    bad_f3    = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (st && f3[2]);
    bad_align = ((f3[1:0] == 2'b01) && a[0]) ||
                ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || bad_align;
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] o);
    case (f3[1:0])
      2'b00:   return 4'b0001 << o;
      2'b01:   return o[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Signed views of the shifted lane give the sign extension for LB/LH.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] o,
                                               input logic [31:0] rd);
    logic [31:0]        s;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    s  = rd >> {o, 3'b000};
    sb = s[7:0];
    sh = s[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b010:  return s;
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign req_illegal = illegal_req(req_store, req_funct3, req_addr[1:0]);

  always_comb begin
    state_d    = state_q;
    req_ready  = (state_q == IDLE);
    accept     = req_valid && (state_q == IDLE);
    resp_valid = (state_q == DONE);
    resp_err   = (state_q == DONE) && err_q;
    mem_we     = 4'b0000;
    case (state_q)
      IDLE:    if (accept) state_d = req_illegal ? DONE : ACCESS;
      ACCESS: begin
        if (store_q && rst_n) mem_we = store_mask(funct3_q, addr_q[1:0]);
        state_d = store_q ? DONE : READ;
      end
      READ:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = store_data(funct3_q, wdata_q);
  assign resp_rdata = rdata_q;

  // Request capture, FSM state and the held load result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      store_q  <= 1'b0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr;
        funct3_q <= req_funct3;
        store_q  <= req_store;
        wdata_q  <= req_wdata;
        err_q    <= req_illegal;
        if (req_illegal) rdata_q <= 32'h0;
      end
      if (state_q == ACCESS && store_q) rdata_q <= 32'h0;
      if (state_q == READ) rdata_q <= load_extract(funct3_q, addr_q[1:0], mem_rdata);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane RAM (registered read) attached.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ram_clr;
  logic [31:0] ram [0:1023];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) ram[mem_addr[11:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
      mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                        input logic [3:0] exp_mask, input logic [31:0] exp_wd);
    int  cyc;
    bit  seen;
    @(negedge clk);
    check({tag, " ready"}, {31'h0, req_ready}, 32'h1);
    check({tag, " idle_valid"}, {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      check({tag, " mem_we"}, {28'h0, mem_we}, (cyc == 1 && exp_lat != 1) ? {28'h0, exp_mask} : 32'h0);
      if (cyc == 1 && !exp_err) check({tag, " mem_addr"}, mem_addr, addr & ~32'h3);
      if (cyc == 1 && st && !exp_err) check({tag, " mem_wdata"}, mem_wdata, exp_wd);
      if (resp_valid) begin
        seen = 1;
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " err"}, {31'h0, resp_err}, {31'h0, exp_err});
        check({tag, " rdata"}, resp_rdata, exp_rd);
      end
    end
    check({tag, " resp_seen"}, {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ram_clr = 1'b1;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", {31'h0, req_ready}, 32'h1);
    check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst resp_err", {31'h0, resp_err}, 32'h0);
    check("rst mem_we", {28'h0, mem_we}, 32'h0);
    check("rst rdata", resp_rdata, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1; ram_clr = 1'b0; req_valid = 1'b0;

    do_req("SW10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF);
    do_req("LW10",  1'b0, 3'b010, 32'h10, 32'h0,        3, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0);
    do_req("SB13",  1'b1, 3'b000, 32'h13, 32'h12345680, 2, 1'b0, 32'h0,        4'h8, 32'h80808080);
    do_req("LB13",  1'b0, 3'b000, 32'h13, 32'h0,        3, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0);
    do_req("LBU13", 1'b0, 3'b100, 32'h13, 32'h0,        3, 1'b0, 32'h00000080, 4'h0, 32'h0);
    do_req("LW10b", 1'b0, 3'b010, 32'h10, 32'h0,        3, 1'b0, 32'h80ADBEEF, 4'h0, 32'h0);
    do_req("LBU11", 1'b0, 3'b100, 32'h11, 32'h0,        3, 1'b0, 32'h000000BE, 4'h0, 32'h0);
    do_req("LB10",  1'b0, 3'b000, 32'h10, 32'h0,        3, 1'b0, 32'hFFFFFFEF, 4'h0, 32'h0);
    do_req("SH22",  1'b1, 3'b001, 32'h22, 32'hABCD8001, 2, 1'b0, 32'h0,        4'hC, 32'h80018001);
    do_req("LH22",  1'b0, 3'b001, 32'h22, 32'h0,        3, 1'b0, 32'hFFFF8001, 4'h0, 32'h0);
    do_req("LHU22", 1'b0, 3'b101, 32'h22, 32'h0,        3, 1'b0, 32'h00008001, 4'h0, 32'h0);
    do_req("SH20",  1'b1, 3'b001, 32'h20, 32'h00001234, 2, 1'b0, 32'h0,        4'h3, 32'h12341234);
    do_req("LH20",  1'b0, 3'b001, 32'h20, 32'h0,        3, 1'b0, 32'h00001234, 4'h0, 32'h0);
    do_req("LW20",  1'b0, 3'b010, 32'h20, 32'h0,        3, 1'b0, 32'h80011234, 4'h0, 32'h0);
    @(negedge clk);
    check("rdata hold", resp_rdata, 32'h80011234);

    do_req("ELW21", 1'b0, 3'b010, 32'h21, 32'h0,        1, 1'b1, 32'h0, 4'h0, 32'h0);
    do_req("ESH23", 1'b1, 3'b001, 32'h23, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    do_req("EF011", 1'b0, 3'b011, 32'h24, 32'h0,        1, 1'b1, 32'h0, 4'h0, 32'h0);
    do_req("ESB4",  1'b1, 3'b100, 32'h24, 32'hFFFFFFFF, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    do_req("LW20c", 1'b0, 3'b010, 32'h20, 32'h0,        3, 1'b0, 32'h80011234, 4'h0, 32'h0);
    do_req("LW24",  1'b0, 3'b010, 32'h24, 32'h0,        3, 1'b0, 32'h0,        4'h0, 32'h0);

    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstacc mem_we pre", {28'h0, mem_we}, 32'hF);
    rst_n = 1'b0;
    #1 check("rstacc mem_we gated", {28'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstacc ready", {31'h0, req_ready}, 32'h1);
    check("rstacc rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("rstacc no_resp", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    do_req("LW30",  1'b0, 3'b010, 32'h30, 32'h0,        3, 1'b0, 32'h0,        4'h0, 32'h0);
    do_req("SW30",  1'b1, 3'b010, 32'h30, 32'h12345678, 2, 1'b0, 32'h0,        4'hF, 32'h12345678);
    do_req("LHU32", 1'b0, 3'b101, 32'h32, 32'h0,        3, 1'b0, 32'h00001234, 4'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
